// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, opcode encodings and the
// hazard sequencer state type, used by decode, execute and pipeline control.
package cpu_pkg;
  localparam int OPW  = 4;
  localparam int REGW = 5;
  localparam int AW   = 16;
  localparam int CNTW = 16;

  localparam logic [OPW-1:0] NOP    = 4'd0;
  localparam logic [OPW-1:0] SUB    = 4'd1;
  localparam logic [OPW-1:0] ADD    = 4'd2;
  localparam logic [OPW-1:0] ADDI   = 4'd3;
  localparam logic [OPW-1:0] SHLLI  = 4'd4;
  localparam logic [OPW-1:0] SHRLI  = 4'd5;
  localparam logic [OPW-1:0] JUMP   = 4'd6;
  localparam logic [OPW-1:0] JUMPL  = 4'd7;
  localparam logic [OPW-1:0] JUMPG  = 4'd8;
  localparam logic [OPW-1:0] JUMPE  = 4'd9;
  localparam logic [OPW-1:0] JUMPNE = 4'd10;
  localparam logic [OPW-1:0] CMP    = 4'd11;
  localparam logic [OPW-1:0] LOAD   = 4'd12;
  localparam logic [OPW-1:0] LOADI  = 4'd13;
  localparam logic [OPW-1:0] STORE  = 4'd14;
  localparam logic [OPW-1:0] MOV    = 4'd15;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    SQUASH = 2'd2
  } state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/Execute observation signals and the stall/flush/redirect controls.
// The master side is the pipeline datapath; the slave side is the hazard controller.
interface pipeline_hazard_ctrl_if;
  import cpu_pkg::*;

  logic [OPW-1:0]  id_opcode;
  logic [REGW-1:0] id_src1_idx;
  logic [REGW-1:0] id_src2_idx;
  logic            id_src1_used;
  logic            id_src2_used;
  logic [OPW-1:0]  ex_opcode;
  logic [REGW-1:0] ex_dest_idx;
  logic            ex_zf;
  logic            ex_gf;
  logic            ex_lf;
  logic [AW-1:0]   ex_target;

  logic            stall_if;
  logic            flush_if_id;
  logic            flush_id_ex;
  logic            pc_sel;
  logic [AW-1:0]   pc_target;
  logic            flag_zf;
  logic            flag_gf;
  logic            flag_lf;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;
  state_t          dbg_state;

  modport master (
    output id_opcode, id_src1_idx, id_src2_idx, id_src1_used, id_src2_used,
    output ex_opcode, ex_dest_idx, ex_zf, ex_gf, ex_lf, ex_target,
    input  stall_if, flush_if_id, flush_id_ex, pc_sel, pc_target,
    input  flag_zf, flag_gf, flag_lf, stall_cnt, flush_cnt, dbg_state
  );

  modport slave (
    input  id_opcode, id_src1_idx, id_src2_idx, id_src1_used, id_src2_used,
    input  ex_opcode, ex_dest_idx, ex_zf, ex_gf, ex_lf, ex_target,
    output stall_if, flush_if_id, flush_id_ex, pc_sel, pc_target,
    output flag_zf, flag_gf, flag_lf, stall_cnt, flush_cnt, dbg_state
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  output logic [CNTW-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNTW'(1);
    end
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, taken-branch flush/redirect, the
// architectural compare flags and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave bus
);
  state_t state, state_nxt;
  logic   flag_zf, flag_gf, flag_lf;
  logic   taken, load_use;
  logic   stall_if, flush_if_id, flush_id_ex, pc_sel;
  logic   unused_id_opcode;

  // The controller only needs operand usage from ID, not the opcode itself.
  assign unused_id_opcode = ^bus.id_opcode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_zf <= 1'b0;
      flag_gf <= 1'b0;
      flag_lf <= 1'b0;
    end else if (bus.ex_opcode == CMP) begin
      flag_zf <= bus.ex_zf;
      flag_gf <= bus.ex_gf;
      flag_lf <= bus.ex_lf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    taken = 1'b0;
    case (bus.ex_opcode)
      JUMP:    taken = 1'b1;
      JUMPL:   taken = flag_lf;
      JUMPG:   taken = flag_gf;
      JUMPE:   taken = flag_zf;
      JUMPNE:  taken = !flag_zf;
      default: taken = 1'b0;
    endcase
  end

  assign load_use = (bus.ex_opcode == LOAD) &&
                    ((bus.id_src1_used && (bus.id_src1_idx == bus.ex_dest_idx)) ||
                     (bus.id_src2_used && (bus.id_src2_idx == bus.ex_dest_idx)));

  // Controls are gated by rst_n so a pending redirect vanishes the moment reset asserts.
  always_comb begin
    state_nxt   = RUN;
    stall_if    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    pc_sel      = 1'b0;
    if (rst_n) begin
      case (state)
        RUN, SQUASH: begin
          if (taken) begin
            pc_sel      = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            state_nxt   = SQUASH;
          end else if (load_use) begin
            stall_if    = 1'b1;
            flush_id_ex = 1'b1;
            state_nxt   = LSTALL;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign bus.stall_if    = stall_if;
  assign bus.flush_if_id = flush_if_id;
  assign bus.flush_id_ex = flush_id_ex;
  assign bus.pc_sel      = pc_sel;
  assign bus.pc_target   = pc_sel ? bus.ex_target : '0;
  assign bus.flag_zf     = flag_zf;
  assign bus.flag_gf     = flag_gf;
  assign bus.flag_lf     = flag_lf;
  assign bus.dbg_state   = state;

  sat_counter #(.CNTW(CNTW)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_if),
    .count (bus.stall_cnt)
  );

  sat_counter #(.CNTW(CNTW)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_sel),
    .count (bus.flush_cnt)
  );
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central pipeline sequencer for the 16-bit 5-stage core. It watches the instructions in Decode and Execute and produces stall, flush and PC-redirect controls. It owns the architectural compare-flag register (ZF/GF/LF), loaded by CMP, and resolves conditional jumps in EX. It keeps saturating stall and flush counters for debug and performance.

Parameters:
OPW, 4, opcode width (NOP=0, SUB=1, ADD=2, ADDI=3, SHLLI=4, SHRLI=5, JUMP=6, JUMPL=7, JUMPG=8, JUMPE=9, JUMPNE=10, CMP=11, LOAD=12, LOADI=13, STORE=14, MOV=15)
REGW, 5, register index width
AW, 16, PC/target width
CNTW, 16, performance counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
id_opcode  in  OPW  opcode in ID stage
id_src1_idx  in  REGW  ID source index 1
id_src2_idx  in  REGW  ID source index 2
id_src1_used  in  1  src1 is read by the ID instruction
id_src2_used  in  1  src2 is read by the ID instruction
ex_opcode  in  OPW  opcode in EX stage
ex_dest_idx  in  REGW  EX destination index
ex_zf, ex_gf, ex_lf  in  1 each  combinational compare result from Execute
ex_target  in  AW  branch target computed by Execute
stall_if  out  1  hold PC and the IF/ID register
flush_if_id  out  1  clear IF/ID to NOP
flush_id_ex  out  1  clear ID/EX to NOP (bubble)
pc_sel  out  1  1 = next PC is pc_target
pc_target  out  AW  redirect address
flag_zf, flag_gf, flag_lf  out  1 each  architectural flags
stall_cnt  out  CNTW  load-use stall cycles, saturating
flush_cnt  out  CNTW  taken-branch flushes, saturating

Behaviour:
- Interface: one clock `clk`. Reset is asynchronous and active-low (`rst_n`).
- Reset: all outputs 0, flags 0, counters 0, FSM in RUN.
- Flag register:
  - Loads ex_zf/gf/lf at the clock edge when ex_opcode==CMP.
  - Otherwise it holds.
  - A jump in EX in the cycle directly after CMP sees the updated flags, with no bypass needed.
- Branch condition (combinational, EX):
  - JUMP: always taken.
  - JUMPL: taken if flag_lf. JUMPG: flag_gf. JUMPE: flag_zf. JUMPNE: !flag_zf.
  - All other opcodes: not taken.
- Load-use hazard: ex_opcode==LOAD AND ((id_src1_used && id_src1_idx==ex_dest_idx) OR (id_src2_used && id_src2_idx==ex_dest_idx)).
- FSM states:
  - RUN, no hazard: all controls 0.
  - RUN, taken branch: assert pc_sel=1, pc_target=ex_target, flush_if_id=1, flush_id_ex=1, all in the same cycle (combinational). Go to SQUASH.
  - RUN, load-use hazard and no taken branch: assert stall_if=1 and flush_id_ex=1 for exactly 1 cycle. Go to LSTALL.
  - LSTALL: all controls 0; hazard detection is suppressed. The held instruction advances. Return to RUN.
  - SQUASH: EX holds the flushed bubble. Controls are 0; detection is still evaluated, but EX is NOP so nothing fires. Return to RUN.
- Simultaneous taken branch and load-use: the branch wins. No stall is asserted and stall_cnt does not increment.
- Two back-to-back taken jumps are impossible: the second is flushed. If one appears anyway (e.g. an injected test), a taken branch in SQUASH is honoured exactly as in RUN.
- Counters:
  - stall_cnt increments on each cycle with stall_if=1.
  - flush_cnt increments on each cycle with pc_sel=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation: clears everything immediately, including any pending redirect. pc_sel drops asynchronously.
- All control outputs are combinational from state, inputs and flags. Flags, counters and state are registered. Latency from a hazard to its control is 0 cycles.

Decomposition:
- Shared package (`cpu_pkg`): opcode localparams NOP..MOV, the OPW/REGW/AW widths, and the FSM state enum {RUN, LSTALL, SQUASH}. The Execute stage and decoder reuse the same package.
- One sub-module, `sat_counter` (param CNTW; inputs clk, rst_n, inc; output count), instantiated twice for the counters.

Test Plan:
- Reset asserted mid-SQUASH with pc_sel=1 -> pc_sel, flags and counters read 0 immediately, and state is RUN on release.
- CMP with R1=4, R2=8 (ex_lf=1), then JUMPL with ex_target=0x0021 -> flag_lf=1, pc_sel=1, pc_target=0x0021, both flushes high for 1 cycle, flush_cnt=1.
- CMP with 7,7 (ZF=1), then JUMPNE -> not taken: pc_sel=0, no flush. Then JUMPE -> taken.
- LOAD with dest R8 in EX, ADD in ID reading src1=R8 (used) -> stall_if=1 and flush_id_ex=1 for exactly 1 cycle, then 0 in LSTALL, stall_cnt=1. The same with src1_used=0 -> no stall.
- LOAD with dest R3 in EX plus taken JUMP in EX-equivalent injection (ex_opcode=JUMP, ID reads R3, prior LOAD forced) -> branch controls only, stall_cnt unchanged.
- Counter saturation: preload via 65535 forced JUMPs -> flush_cnt=0xFFFF, and it stays 0xFFFF on the next taken jump.
